// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, WIDTH cycles per operation.
// Define DIVIDER_SIGNED_EN to honour sgn (two's-complement operands); otherwise all unsigned.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sgn,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

`ifdef DIVIDER_SIGNED_EN
  assign a_neg = sgn & A[WIDTH-1];
  assign b_neg = sgn & B[WIDTH-1];
`else
  logic unused_sgn;
  assign a_neg      = 1'b0;
  assign b_neg      = 1'b0;
  assign unused_sgn = sgn;
`endif

  assign a_abs = a_neg ? -A : A;
  assign b_abs = b_neg ? -B : B;

  // The shifted remainder can need WIDTH+1 bits, so the trial difference is kept one bit wider.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [1:0]       unused_bits;

  assign shifted     = {rem_q, dvd_q[WIDTH-1]};
  assign trial       = {1'b0, shifted} - {2'b00, b_q};
  assign fits        = ~trial[WIDTH+1];
  assign rem_next    = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next    = {quo_q[WIDTH-2:0], fits};
  assign unused_bits = {trial[WIDTH], quo_q[WIDTH-1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    dvd_d   = dvd_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          state_d = StRun;
          a_d     = A;
          dvd_d   = a_abs;
          b_d     = b_abs;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
        end
      end
      StRun: begin
        if (b_q == '0) begin
          state_d = StDone;
          q_d     = '1;
          r_d     = a_q;
          dbz_d   = 1'b1;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          dvd_d = dvd_q << 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = StDone;
            q_d     = qneg_q ? -quo_next : quo_next;
            r_d     = rneg_q ? -rem_next : rem_next;
            dbz_d   = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      dvd_q   <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      dvd_q   <= dvd_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32): latency, results, divide-by-zero, reset abort,
// back-to-back starts; signed vectors when DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        sgn = 1'b0;
  logic [31:0] Q, R;
  logic        busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .sgn         (sgn),
    .Q           (Q),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; start is sampled by the following rising edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    A = a;
    B = b;
    sgn = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int lat, input logic [31:0] eq,
                           input logic [31:0] er, input logic edbz);
    while (!done && (cyc - t0) < 100) @(negedge clk);
    check({tag, "_lat"}, 32'(cyc - t0), 32'(lat));
    check({tag, "_q"}, Q, eq);
    check({tag, "_r"}, R, er);
    check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input int lat);
    launch(a, b, s);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    check({tag, "_nodone"}, {31'b0, done}, 32'd0);
    wait_done(tag, lat, eq, er, edbz);
  endtask

  int pulses;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_q", Q, 32'd0);
    check("rst_r", R, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;

    do_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32);
    @(negedge clk);
    check("hold_done", {31'b0, done}, 32'd0);
    check("hold_q", Q, 32'd14);
    check("hold_r", R, 32'd2);

    do_div("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 32);
    do_div("u5_9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 32);
    do_div("uwide", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 1'b0, 32);
    do_div("dbz", 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    do_div("after_dbz", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 32);

    // Back-to-back: relaunch from the DONE cycle left by the previous call.
    do_div("b2b", 32'd77, 32'd8, 1'b0, 32'd9, 32'd5, 1'b0, 32);

    // start during RUN must not disturb the operation in flight.
    launch(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    A = 32'd9;
    B = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("midstart", 32, 32'd333, 32'd1, 1'b0);

    // Reset mid-run: outputs clear at once and the abandoned op never completes.
    launch(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    A = 32'd9;
    B = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    check("arst_q", Q, 32'd0);
    check("arst_r", R, 32'd0);
    check("arst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("arst_nopulse", 32'(pulses), 32'd0);
    do_div("post_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 32);

`ifdef DIVIDER_SIGNED_EN
    do_div("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32);
    do_div("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 32);
    do_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 32);
    do_div("s_dbz", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
    do_div("s_off", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 32);
`else
    do_div("sgn_ign", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 32);
    do_div("sgn_ign_dbz", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
